// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Purpose:
//     Multiplexed NUM_DIGITS-digit hex display driver for 7-segment banks.
//     A packed hex value and its decimal points are captured through a
//     load/ready handshake into a shadow register. The shadow is copied into
//     the displayed register only at the end of a full scan frame, so a frame
//     never mixes old and new digits. One digit is driven per refresh slot.
//     The driver also provides leading-zero blanking, per-digit decimal points
//     and whole-display blinking.
//
// Parameters:
//     NUM_DIGITS    digits scanned (>= 1); value width is 4*NUM_DIGITS
//     REFRESH_DIV   clk cycles per digit slot (>= 2)
//     BLINK_FRAMES  full scan frames per blink half-period (>= 1)
//     ACTIVE_LOW    1: seg/dp/digit_sel are active-low; 0: active-high
//
// Ports:
//     clk_i          system clock; all logic runs on the rising edge
//     reset_i        synchronous, active-high reset
//     value_i        packed hex digits; [3:0] is digit 0 (rightmost)
//     dp_in_i        decimal point per digit, captured together with value_i
//     load_i         capture request; accepted only while ready_o = 1
//     lz_en_i        leading-zero suppression enable (live, not captured)
//     blink_en_i     blink enable (live)
//     ready_o        1 = no update pending, a load is accepted
//     seg_o          segments, bit 0 = a ... bit 6 = g
//     dp_o           decimal point of the active digit
//     digit_sel_o    one-hot digit enable
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_in_i,
    input  logic                    load_i,
    input  logic                    lz_en_i,
    input  logic                    blink_en_i,
    output logic                    ready_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   digit_sel_o
);

    // -------------------------------------------------------------------------
    // Widths and constants
    // -------------------------------------------------------------------------
    // Counters need at least one bit even when they only ever hold 0.
    localparam int IDX_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    // Pin levels for "everything off" in the selected polarity.
    localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF   = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] DSEL_OFF = {NUM_DIGITS{ACTIVE_LOW}};

    // -------------------------------------------------------------------------
    // Hex to segment decode, active-high form (bit 0 = a ... bit 6 = g)
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Bit i is set when digit i and every digit to its left are zero.
    // The running AND walks from the most significant digit downwards.
    function automatic logic [NUM_DIGITS-1:0] upper_zero_mask(
        input logic [VAL_W-1:0] v
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (v[4*i +: 4] == 4'h0);
            mask[i]  = all_zero;
        end
        return mask;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [VAL_W-1:0]      disp_val_q,   disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q,    disp_dp_d;
    logic [VAL_W-1:0]      pend_val_q,   pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q,    pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [PRESC_W-1:0]    presc_q,      presc_d;
    logic [IDX_W-1:0]      scan_idx_q,   scan_idx_d;
    logic [BLINK_W-1:0]    blink_cnt_q,  blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [6:0]            seg_q,        seg_d;
    logic                  dp_q,         dp_d;
    logic [NUM_DIGITS-1:0] digit_sel_q,  digit_sel_d;

    // Combinational helpers
    logic                  ready;
    logic                  tick;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [6:0]            seg_raw;
    logic                  dp_raw;

    // Nothing can be pending while ready is high, so a load and a commit
    // can never coincide.
    assign ready      = ~pend_valid_q;
    assign upper_zero = upper_zero_mask(disp_val_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        tick          = (presc_q == PRESC_LAST);
        frame_end     = tick && (scan_idx_q == IDX_LAST);

        presc_d       = tick ? '0 : presc_q + 1'b1;
        scan_idx_d    = scan_idx_q;
        disp_val_d    = disp_val_q;
        disp_dp_d     = disp_dp_q;
        pend_val_d    = pend_val_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        cur_nib       = 4'h0;
        cur_dp        = 1'b0;
        cur_blank     = 1'b0;
        sel_onehot    = '0;

        // Digit scan; with a single digit the index simply stays at 0.
        if (tick) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end

        // Load into the shadow register.
        if (load_i && ready) begin
            pend_val_d   = value_i;
            pend_dp_d    = dp_in_i;
            pend_valid_d = 1'b1;
        end

        // Commit at the frame boundary so the next frame starts cleanly on
        // digit 0 with the new data.
        if (frame_end && pend_valid_q) begin
            disp_val_d   = pend_val_q;
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
        end

        // Blink timing: counts whole frames while enabled; disabling clears it
        // so a re-enable always starts with a visible half-period.
        if (!blink_en_i) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Select the active digit's data.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cur_nib       = disp_val_q[4*i +: 4];
                cur_dp        = disp_dp_q[i];
                // Digit 0 is never blanked so an all-zero value still shows "0".
                cur_blank     = lz_en_i && (i != 0) && upper_zero[i];
                sel_onehot[i] = 1'b1;
            end
        end

        // Blanking removes only the segments; the decimal point still follows
        // the captured dp bit. Blink removes both but keeps the scan running.
        seg_raw = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
        dp_raw  = cur_dp;
        if (blink_phase_q) begin
            seg_raw = 7'h00;
            dp_raw  = 1'b0;
        end

        seg_d       = seg_raw ^ SEG_OFF;
        dp_d        = dp_raw ^ DP_OFF;
        digit_sel_d = sel_onehot ^ DSEL_OFF;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (reset_i) begin
            // NOTE: the shadow data is cleared as well, not only its valid bit,
            // so a pending update is discarded and nothing stale survives reset.
            disp_val_q    <= '0;
            disp_dp_q     <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            presc_q       <= '0;
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            digit_sel_q   <= DSEL_OFF;
        end else begin
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            presc_q       <= presc_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            digit_sel_q   <= digit_sel_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ready_o     = ready;
    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign digit_sel_o = digit_sel_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_driver
//
// Self-checking bench for seven_seg_scan_driver with NUM_DIGITS=4,
// REFRESH_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1. One scan frame is 16 clocks.
// Expected per-digit pin values are pushed into a queue when a load is driven
// and popped as the DUT scans each digit of the following frame.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int FRAME = 16;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] value_i;
    logic [3:0]  dp_in_i;
    logic        load_i;
    logic        lz_en_i;
    logic        blink_en_i;
    logic        ready_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  digit_sel_o;

    always #5 clk_i = ~clk_i;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .value_i     (value_i),
        .dp_in_i     (dp_in_i),
        .load_i      (load_i),
        .lz_en_i     (lz_en_i),
        .blink_en_i  (blink_en_i),
        .ready_o     (ready_o),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .digit_sel_o (digit_sel_o)
    );

    // Expected pin levels for one digit slot.
    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
    } exp_t;

    // Table vector: codes are the active-high segment patterns {d3,d2,d1,d0};
    // 7'h00 marks a blanked digit.
    typedef struct {
        string       name;
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lz;
        logic [27:0] codes;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    int k;        // clock edges since reset was released
    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, req, k);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        if (reset_i) k = 0;
        else k++;
        #2;
    endtask

    // Step until the edge count sits at the given position within a frame.
    task automatic align(input int pos);
        for (int g = 0; g < FRAME && (k % FRAME) != pos; g++) step();
    endtask

    task automatic push_frame(input logic [27:0] codes, input logic [3:0] dp_on, input logic off);
        for (int i = 0; i < 4; i++) begin
            exp_t       e;
            logic [6:0] c;
            c     = codes[7*i +: 7];
            e.seg = off ? 7'h7F : ~c;
            e.dp  = off ? 1'b1 : ~dp_on[i];
            e.sel = ~(4'b0001 << i);
            exp_q.push_back(e);
        end
    endtask

    // Called at a frame boundary; checks all 16 slots of the next frame.
    // drop_blink releases blink_en just before the frame's last edge.
    task automatic check_frame(input string tag, input logic drop_blink);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s_queue_d%0d", tag, d), 0, 1);
                return;
            end
            e = exp_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                if (drop_blink && d == 3 && c == 3) blink_en_i = 1'b0;
                step();
                check($sformatf("%s_d%0d_seg", tag, d), seg_o, e.seg);
                check($sformatf("%s_d%0d_dp", tag, d), dp_o, e.dp);
                check($sformatf("%s_d%0d_sel", tag, d), digit_sel_o, e.sel);
            end
        end
    endtask

    // Load mid-frame, wait for the commit, then check the new frame.
    task automatic load_and_commit(input string tag, input logic [15:0] value,
                                   input logic [3:0] dp, input logic lz,
                                   input logic [27:0] codes);
        align(6);
        lz_en_i = lz;
        value_i = value;
        dp_in_i = dp;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
        check({tag, "_ready_low"}, ready_o, 1'b0);
        push_frame(codes, dp, 1'b0);
        align(0);
        check({tag, "_ready_high"}, ready_o, 1'b1);
        check_frame(tag, 1'b0);
    endtask

    task automatic set_vec(input int i, input string name, input logic [15:0] value,
                           input logic [3:0] dp, input logic lz, input logic [27:0] codes);
        vecs[i].name  = name;
        vecs[i].value = value;
        vecs[i].dp    = dp;
        vecs[i].lz    = lz;
        vecs[i].codes = codes;
    endtask

    initial begin
        logic [27:0] zeros_lz0;
        logic [27:0] codes_1a3f;
        logic [27:0] codes_2479;

        zeros_lz0  = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
        codes_1a3f = {7'h06, 7'h77, 7'h4F, 7'h71};
        codes_2479 = {7'h5B, 7'h66, 7'h07, 7'h6F};

        set_vec(0, "hex_1a3f_lz1", 16'h1A3F, 4'b0100, 1'b1, codes_1a3f);
        set_vec(1, "lz_0050",      16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F});
        set_vec(2, "lz_0000",      16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F});
        set_vec(3, "zero_dp_lz0",  16'h0000, 4'b1010, 1'b0, zeros_lz0);
        set_vec(4, "lz_blank_dp3", 16'h0000, 4'b1000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F});
        set_vec(5, "hex_2479",     16'h2479, 4'b0000, 1'b0, codes_2479);
        set_vec(6, "hex_edc8",     16'hEDC8, 4'b0011, 1'b1, {7'h79, 7'h5E, 7'h39, 7'h7F});
        set_vec(7, "lz_0b06",      16'h0B06, 4'b0000, 1'b1, {7'h00, 7'h7C, 7'h3F, 7'h7D});

        checks     = 0;
        errors     = 0;
        k          = 0;
        reset_i    = 1'b1;
        value_i    = '0;
        dp_in_i    = '0;
        load_i     = 1'b0;
        lz_en_i    = 1'b0;
        blink_en_i = 1'b0;

        // Reset state: everything off, ready high.
        step();
        check("reset_seg", seg_o, 7'h7F);
        check("reset_dp", dp_o, 1'b1);
        check("reset_sel", digit_sel_o, 4'hF);
        check("reset_ready", ready_o, 1'b1);
        step();
        reset_i = 1'b0;

        // Idle scan of an all-zero display, without and with zero blanking.
        push_frame(zeros_lz0, 4'b0000, 1'b0);
        check_frame("idle_lz0", 1'b0);
        lz_en_i = 1'b1;
        push_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 1'b0);
        check_frame("idle_lz1", 1'b0);

        // Mid-frame load; a second load while busy is dropped; the old data
        // stays on screen until the frame boundary.
        lz_en_i = 1'b0;
        align(6);
        value_i = 16'h1A3F;
        dp_in_i = 4'b0100;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
        check("load_ready_low", ready_o, 1'b0);
        push_frame(codes_1a3f, 4'b0100, 1'b0);
        step();
        step();
        value_i = 16'hFFFF;
        dp_in_i = 4'b1111;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
        check("busy_load_ready", ready_o, 1'b0);
        for (int g = 0; g < FRAME && (k % FRAME) != 0; g++) begin
            step();
            check("old_frame_seg", seg_o, 7'h40);
            check("old_frame_dp", dp_o, 1'b1);
        end
        check("commit_ready", ready_o, 1'b1);
        check_frame("show_1a3f", 1'b0);
        push_frame(codes_1a3f, 4'b0100, 1'b0);
        check_frame("still_1a3f", 1'b0);
        check("no_queued_load", ready_o, 1'b1);

        // Load arriving on the very edge of a commit is ignored.
        align(6);
        value_i = 16'h2222;
        dp_in_i = 4'b0001;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
        align(15);
        value_i = 16'h7777;
        dp_in_i = 4'b1000;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
        check("collide_ready", ready_o, 1'b1);
        push_frame({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0001, 1'b0);
        check_frame("collide_frame", 1'b0);
        check("collide_nothing_pending", ready_o, 1'b1);
        push_frame({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0001, 1'b0);
        check_frame("collide_frame2", 1'b0);

        // Table-driven decode / blanking / decimal-point vectors.
        for (int v = 0; v < 8; v++) begin
            load_and_commit(vecs[v].name, vecs[v].value, vecs[v].dp, vecs[v].lz, vecs[v].codes);
        end

        // Blink: two frames on, two off; releasing blink_en clears the phase.
        load_and_commit("blink_src", 16'h2479, 4'b1111, 1'b0, codes_2479);
        blink_en_i = 1'b1;
        for (int f = 1; f <= 10; f++) begin
            push_frame(codes_2479, 4'b1111, (f == 3 || f == 4 || f == 7 || f == 8));
            check_frame($sformatf("blink_f%0d", f), (f == 10));
        end
        push_frame(codes_2479, 4'b1111, 1'b0);
        check_frame("blink_cleared", 1'b0);

        // Reset while an update is pending discards it.
        lz_en_i = 1'b0;
        align(6);
        value_i = 16'h8888;
        dp_in_i = 4'b1111;
        load_i  = 1'b1;
        step();
        load_i  = 1'b0;
        check("pre_reset_ready_low", ready_o, 1'b0);
        step();
        step();
        step();
        reset_i = 1'b1;
        step();
        check("midreset_ready", ready_o, 1'b1);
        check("midreset_seg", seg_o, 7'h7F);
        check("midreset_dp", dp_o, 1'b1);
        check("midreset_sel", digit_sel_o, 4'hF);
        reset_i = 1'b0;
        push_frame(zeros_lz0, 4'b0000, 1'b0);
        check_frame("post_reset", 1'b0);
        push_frame(zeros_lz0, 4'b0000, 1'b0);
        check_frame("no_stale_pending", 1'b0);
        check("post_reset_ready", ready_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
